// File: rtl/router_ctrl_if.sv
// Source/FIFO-side control bundle for router_ctrl_fsm: status inputs plus the
// registered state decodes that steer the register and FIFO datapath.
interface router_ctrl_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] soft_reset;
    logic              parity_done;
    logic              low_packet_valid;

    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              write_enb_reg;
    logic              busy;
    logic              drop_state;
    logic [NUM_CH-1:0] dest_sel;
    logic              wait_timeout;

    modport master (
        output pkt_valid, data_in, fifo_empty, fifo_full, soft_reset,
               parity_done, low_packet_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, drop_state, dest_sel, wait_timeout
    );

    modport slave (
        input  pkt_valid, data_in, fifo_empty, fifo_full, soft_reset,
               parity_done, low_packet_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, drop_state, dest_sel, wait_timeout
    );
endinterface

// File: rtl/router_ctrl_fsm.sv
// NUM_CH-channel packet-router control FSM with registered Moore outputs.
// Optional wait-for-empty timeout enabled by ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_ctrl_fsm #(
    parameter int NUM_CH     = 3,
    parameter int ADDR_W     = 2,
    parameter int WAIT_LIMIT = 16
) (
    input logic         clock,
    input logic         resetn,
    router_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        WAIT_TILL_EMPTY    = 4'd2,
        LOAD_DATA          = 4'd3,
        LOAD_PARITY        = 4'd4,
        FIFO_FULL_STATE    = 4'd5,
        LOAD_AFTER_FULL    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    localparam int SPAN = 1 << ADDR_W;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] dest_q, dest_nx;
    logic [SPAN-1:0]   empty_ext;
    logic              addr_ok, e_d, f_d, s_d, timeout;

    // Zero-extend so an out-of-range header can be indexed safely.
    assign empty_ext = SPAN'(bus.fifo_empty);
    assign addr_ok   = ({1'b0, bus.data_in} < (ADDR_W+1)'(NUM_CH));
    assign e_d       = bus.fifo_empty[dest_q];
    assign f_d       = bus.fifo_full[dest_q];
    assign s_d       = bus.soft_reset[dest_q];

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam int CW = $clog2(WAIT_LIMIT + 1);
    logic [CW-1:0] wait_cnt;

    // Fires on the cycle whose increment would reach WAIT_LIMIT; empty wins.
    assign timeout = (state == WAIT_TILL_EMPTY) && !e_d && !s_d &&
                     (wait_cnt == CW'(WAIT_LIMIT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            wait_cnt <= '0;
        else if (state != WAIT_TILL_EMPTY && state_nx == WAIT_TILL_EMPTY)
            wait_cnt <= '0;
        else if (state == WAIT_TILL_EMPTY && !e_d)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        dest_nx  = dest_q;
        case (state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    if (!addr_ok) begin
                        state_nx = DROP_PACKET;
                    end else begin
                        dest_nx  = bus.data_in;
                        state_nx = empty_ext[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (e_d)          state_nx = LOAD_FIRST_DATA;
                else if (timeout) state_nx = DROP_PACKET;
            end
            LOAD_FIRST_DATA: state_nx = LOAD_DATA;
            LOAD_DATA: begin
                if (f_d)                 state_nx = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_nx = LOAD_PARITY;
            end
            LOAD_PARITY:     state_nx = CHECK_PARITY_ERROR;
            FIFO_FULL_STATE: state_nx = f_d ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)           state_nx = DECODE_ADDRESS;
                else if (bus.low_packet_valid) state_nx = LOAD_PARITY;
                else                           state_nx = LOAD_DATA;
            end
            CHECK_PARITY_ERROR: state_nx = f_d ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET:        if (!bus.pkt_valid) state_nx = DECODE_ADDRESS;
            default:            state_nx = DECODE_ADDRESS;
        endcase
        // Destination soft reset aborts any in-flight packet.
        if (s_d && state != DECODE_ADDRESS && state != DROP_PACKET)
            state_nx = DECODE_ADDRESS;
    end

    // Outputs decode the next state so they are registered alongside it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state             <= DECODE_ADDRESS;
            dest_q            <= '0;
            bus.detect_add    <= 1'b1;
            bus.lfd_state     <= 1'b0;
            bus.ld_state      <= 1'b0;
            bus.laf_state     <= 1'b0;
            bus.full_state    <= 1'b0;
            bus.rst_int_reg   <= 1'b0;
            bus.write_enb_reg <= 1'b0;
            bus.busy          <= 1'b0;
            bus.drop_state    <= 1'b0;
            bus.dest_sel      <= '0;
            bus.wait_timeout  <= 1'b0;
        end else begin
            state             <= state_nx;
            dest_q            <= dest_nx;
            bus.detect_add    <= (state_nx == DECODE_ADDRESS);
            bus.lfd_state     <= (state_nx == LOAD_FIRST_DATA);
            bus.ld_state      <= (state_nx == LOAD_DATA);
            bus.laf_state     <= (state_nx == LOAD_AFTER_FULL);
            bus.full_state    <= (state_nx == FIFO_FULL_STATE);
            bus.rst_int_reg   <= (state_nx == CHECK_PARITY_ERROR);
            bus.write_enb_reg <= (state_nx == LOAD_DATA) || (state_nx == LOAD_PARITY) ||
                                 (state_nx == LOAD_AFTER_FULL);
            bus.busy          <= (state_nx == LOAD_FIRST_DATA) || (state_nx == WAIT_TILL_EMPTY) ||
                                 (state_nx == LOAD_PARITY) || (state_nx == FIFO_FULL_STATE) ||
                                 (state_nx == LOAD_AFTER_FULL) || (state_nx == CHECK_PARITY_ERROR);
            bus.drop_state    <= (state_nx == DROP_PACKET);
            bus.dest_sel      <= (state_nx == DECODE_ADDRESS || state_nx == DROP_PACKET) ?
                                 '0 : (NUM_CH'(1) << dest_nx);
            bus.wait_timeout  <= timeout;
        end
    end
endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Scoreboard bench for router_ctrl_fsm: a phase-level packet model predicts the
// registered decodes for every driven cycle; a monitor pops and compares.
module tb_router_ctrl_fsm;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 2;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam int WAIT_LIMIT = 4;
`else
    localparam int WAIT_LIMIT = 16;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    router_ctrl_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus();

    router_ctrl_fsm #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct packed {
        logic detect_add, lfd, ld, laf, full, rst_int, wen, busy, drop, wto;
        logic [NUM_CH-1:0] dsel;
    } obs_t;

    typedef enum {P_IDLE, P_FIRST, P_WAIT, P_LOAD, P_PAR, P_FULL, P_AFTER, P_CHK, P_DROP} ph_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;
    ph_t  ph      = P_IDLE;
    int   dst     = 0;
    int   waited  = 0;

    function automatic obs_t observe();
        obs_t o;
        o.detect_add = bus.detect_add;   o.lfd  = bus.lfd_state;
        o.ld         = bus.ld_state;     o.laf  = bus.laf_state;
        o.full       = bus.full_state;   o.rst_int = bus.rst_int_reg;
        o.wen        = bus.write_enb_reg; o.busy = bus.busy;
        o.drop       = bus.drop_state;   o.wto  = bus.wait_timeout;
        o.dsel       = bus.dest_sel;
        return o;
    endfunction

    function automatic obs_t expect_of(ph_t p, int d, logic to);
        obs_t o;
        o.detect_add = (p == P_IDLE);
        o.lfd        = (p == P_FIRST);
        o.ld         = (p == P_LOAD);
        o.laf        = (p == P_AFTER);
        o.full       = (p == P_FULL);
        o.rst_int    = (p == P_CHK);
        o.drop       = (p == P_DROP);
        o.wen        = p inside {P_LOAD, P_PAR, P_AFTER};
        o.busy       = p inside {P_FIRST, P_WAIT, P_PAR, P_FULL, P_AFTER, P_CHK};
        o.wto        = to;
        o.dsel       = (p == P_IDLE || p == P_DROP) ? '0 : NUM_CH'(1 << d);
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got=%h want=%h", name, n_cyc, got, want);
        end
    endtask

    // Packet-level rules: where the packet is, which FIFO it targets, how long it waited.
    task automatic model_step();
        ph_t  n;
        logic to, e, f, s;
        n  = ph;
        to = 1'b0;
        e  = bus.fifo_empty[dst];
        f  = bus.fifo_full[dst];
        s  = bus.soft_reset[dst];
        case (ph)
            P_IDLE: if (bus.pkt_valid) begin
                if (int'(bus.data_in) >= NUM_CH) n = P_DROP;
                else begin
                    dst    = int'(bus.data_in);
                    waited = 0;
                    n      = bus.fifo_empty[dst] ? P_FIRST : P_WAIT;
                end
            end
            P_WAIT: begin
                if (e) n = P_FIRST;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
                else begin
                    waited++;
                    if (waited >= WAIT_LIMIT) begin n = P_DROP; to = 1'b1; end
                end
`endif
            end
            P_FIRST: n = P_LOAD;
            P_LOAD:  if (f) n = P_FULL; else if (!bus.pkt_valid) n = P_PAR;
            P_PAR:   n = P_CHK;
            P_FULL:  n = f ? P_FULL : P_AFTER;
            P_AFTER: n = bus.parity_done ? P_IDLE : (bus.low_packet_valid ? P_PAR : P_LOAD);
            P_CHK:   n = f ? P_FULL : P_IDLE;
            P_DROP:  if (!bus.pkt_valid) n = P_IDLE;
            default: n = P_IDLE;
        endcase
        if (s && !(ph inside {P_IDLE, P_DROP})) begin n = P_IDLE; to = 1'b0; end
        ph = n;
        exp_q.push_back(expect_of(n, dst, to));
    endtask

    task automatic cyc(input logic pv, input logic [1:0] din, input logic [2:0] emp,
                       input logic [2:0] full, input logic [2:0] sr, input logic pd, input logic lpv);
        bus.pkt_valid = pv;   bus.data_in = din;   bus.fifo_empty = emp;
        bus.fifo_full = full; bus.soft_reset = sr; bus.parity_done = pd;
        bus.low_packet_valid = lpv;
        model_step();
        @(negedge clock);
    endtask

    task automatic drain();
        repeat (4) cyc(1'b0, 2'd0, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic hard_reset(input string name);
        #2 resetn = 1'b0;
        #1 check(name, observe(), expect_of(P_IDLE, 0, 1'b0));
        ph = P_IDLE; dst = 0; waited = 0;
        bus.pkt_valid = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    function automatic logic [2:0] rbits(input int p);
        logic [2:0] b;
        for (int i = 0; i < 3; i++) b[i] = ($urandom % p) == 0;
        return b;
    endfunction

    initial begin : monitor
        obs_t w;
        forever begin
            @(posedge clock);
            #1;
            n_cyc++;
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("cycle", observe(), w);
            end
        end
    end

    initial begin : driver
        bus.pkt_valid = 1'b0; bus.data_in = '0; bus.fifo_empty = '0; bus.fifo_full = '0;
        bus.soft_reset = '0; bus.parity_done = 1'b0; bus.low_packet_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_state", observe(), expect_of(P_IDLE, 0, 1'b0));
        resetn = 1'b1;
        @(negedge clock);

        // addr 1, empty destination, 4 payload beats then parity
        cyc(1, 2'd1, 3'b111, 0, 0, 0, 0);
        repeat (4) cyc(1, 2'd1, 3'b111, 0, 0, 0, 0);
        repeat (3) cyc(0, 2'd0, 3'b111, 0, 0, 0, 0);

        // addr 2 waits while its FIFO drains; channel 0 flag toggles
        cyc(1, 2'd2, 3'b011, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 2'd0, {2'b01, i[0]}, 0, 0, 0, 0);
        cyc(0, 2'd0, 3'b111, 0, 0, 0, 0);
        drain();

        // full stall in LOAD_DATA, then low_packet_valid into parity
        cyc(1, 2'd0, 3'b111, 0, 0, 0, 0);
        cyc(1, 2'd0, 3'b111, 0, 0, 0, 0);
        repeat (3) cyc(1, 2'd0, 3'b111, 3'b001, 0, 0, 0);
        cyc(1, 2'd0, 3'b111, 0, 0, 0, 0);
        cyc(0, 2'd0, 3'b111, 0, 0, 0, 1);
        drain();

        // out-of-range header is dropped
        cyc(1, 2'd3, 3'b111, 0, 0, 0, 0);
        repeat (3) cyc(1, 2'd3, 3'b111, 0, 0, 0, 0);
        cyc(0, 2'd3, 3'b111, 0, 0, 0, 0);
        cyc(0, 2'd0, 3'b111, 0, 0, 0, 0);

        // soft reset: foreign channel ignored, destination aborts from FFS
        cyc(1, 2'd1, 3'b111, 0, 0, 0, 0);
        repeat (2) cyc(1, 2'd1, 3'b111, 0, 3'b001, 0, 0);
        cyc(1, 2'd1, 3'b111, 3'b010, 0, 0, 0);
        cyc(1, 2'd1, 3'b111, 3'b010, 3'b010, 0, 0);
        drain();

        // asynchronous reset mid-payload
        cyc(1, 2'd2, 3'b111, 0, 0, 0, 0);
        repeat (2) cyc(1, 2'd2, 3'b111, 0, 0, 0, 0);
        hard_reset("reset_mid_packet");
        cyc(0, 2'd0, 3'b111, 0, 0, 0, 0);

        // long wait on a FIFO that never empties (times out when enabled)
        cyc(1, 2'd2, 3'b000, 0, 0, 0, 0);
        repeat (120) cyc(0, 2'd0, 3'b000, 0, 0, 0, 0);
        cyc(0, 2'd0, 3'b111, 0, 0, 0, 0);
        drain();

        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 4) != 0, 2'($urandom_range(0, 3)), rbits(2), rbits(8),
                rbits(40), ($urandom % 8) == 0, ($urandom % 8) == 0);

        repeat (3) @(negedge clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got=%0d pending want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/router_ctrl_fsm.md
# router_ctrl_fsm

Parametrised packet-router control FSM: decodes the header address of an incoming packet, waits for the addressed output FIFO, and sequences header, payload, parity and full-FIFO stalls into the register and FIFO datapath. Generalises the three-channel router controller to NUM_CH channels. Adds per-destination tracking of empty, full and soft-reset; a drop path for headers that decode to no channel; and an optional wait-for-empty timeout. Sits between the source interface and the router register/synchroniser blocks.

## Interface
- NUM_CH, 3: number of output channels, 1..2^ADDR_W.
- ADDR_W, 2: header address field width; channel = data_in[ADDR_W-1:0].
- WAIT_LIMIT, 16: WAIT_TILL_EMPTY timeout in cycles, ≥1; used only with the macro.

- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  source packet valid.
- data_in  in  ADDR_W  header address bits.
- fifo_empty  in  NUM_CH  per-channel FIFO empty.
- fifo_full  in  NUM_CH  per-channel FIFO full.
- soft_reset  in  NUM_CH  per-channel soft reset from read-side timeout.
- parity_done  in  1  parity byte written.
- low_packet_valid  in  1  pkt_valid fell while full.
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy  out  1 each  state decodes.
- drop_state  out  1  discarding an invalid-address packet.
- dest_sel  out  NUM_CH  one-hot latched destination.
- wait_timeout  out  1  one-cycle pulse on timeout (0 without macro).

## Operation
- State register, 4-bit: DECODE_ADDRESS, LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR, DROP_PACKET.
- dest_q register: loaded only in DECODE_ADDRESS when pkt_valid=1 and data_in<NUM_CH. E = fifo_empty[dest_q], F = fifo_full[dest_q], S = soft_reset[dest_q].
- DECODE_ADDRESS: pkt_valid=0 → stay. data_in≥NUM_CH → DROP_PACKET. Otherwise fifo_empty[data_in] → LOAD_FIRST_DATA, else WAIT_TILL_EMPTY.
- WAIT_TILL_EMPTY: E → LOAD_FIRST_DATA, else stay. Other channels' empty flags are ignored.
- LOAD_FIRST_DATA → LOAD_DATA.
- LOAD_DATA: F → FIFO_FULL_STATE. Else pkt_valid=0 → LOAD_PARITY. Else stay.
- LOAD_PARITY → CHECK_PARITY_ERROR.
- FIFO_FULL_STATE: F → stay, else LOAD_AFTER_FULL.
- LOAD_AFTER_FULL: parity_done → DECODE_ADDRESS. Else low_packet_valid → LOAD_PARITY. Else LOAD_DATA.
- CHECK_PARITY_ERROR: F → FIFO_FULL_STATE, else DECODE_ADDRESS.
- DROP_PACKET: pkt_valid=0 → DECODE_ADDRESS, else stay. No writes; busy=0 so the source drains.
- Soft reset: in any state other than DECODE_ADDRESS and DROP_PACKET, S=1 forces next state DECODE_ADDRESS, overriding all other transitions. soft_reset of non-destination channels is ignored.
- Outputs are Moore decodes of the state:
  - detect_add = DECODE_ADDRESS; lfd_state = LOAD_FIRST_DATA; ld_state = LOAD_DATA; laf_state = LOAD_AFTER_FULL; full_state = FIFO_FULL_STATE; rst_int_reg = CHECK_PARITY_ERROR; drop_state = DROP_PACKET.
  - write_enb_reg = LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL.
  - busy = LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL or CHECK_PARITY_ERROR.
  - dest_sel = one-hot(dest_q) except all-zero in DECODE_ADDRESS and DROP_PACKET.

## Timing
- Reset (asynchronous assert, synchronous release): state DECODE_ADDRESS, dest_q=0, timeout counter 0. detect_add=1, all other outputs 0, dest_sel=0.
- One transition per clock; outputs change one cycle after the qualifying input edge, with no combinational path from inputs to outputs.
- Header accepted to lfd_state=1 is 1 cycle when the destination is empty. Last payload with pkt_valid low reaches rst_int_reg=1 in 2 cycles.
- Reset asserted mid-packet: outputs take their reset values immediately, without waiting for a clock edge.

## Configuration
- ROUTER_FSM_WAIT_TIMEOUT_EN defined: a counter clears on entry to WAIT_TILL_EMPTY and increments each cycle there while E=0. When it reaches WAIT_LIMIT, next state is DROP_PACKET and wait_timeout pulses for 1 cycle. E=1 in the same cycle wins.
- Undefined: no counter; WAIT_TILL_EMPTY waits indefinitely; wait_timeout tied 0.

## Test plan
- NUM_CH=3, header addr 1, fifo_empty=3'b111, 4 payload cycles then pkt_valid=0 → state sequence DECODE, LFD, LD×4, LP, CPE, DECODE; dest_sel=3'b010 from LFD through CPE.
- Header addr 2, fifo_empty=3'b011 for 5 cycles then 3'b111 → WAIT for 5 cycles with busy=1, then LFD; a toggling fifo_empty[0] has no effect.
- In LOAD_DATA, fifo_full[dest]=1 for 3 cycles → FFS×3, LAF. Then low_packet_valid=1 → LP, and write_enb_reg=1 in LAF.
- Header addr 3 with NUM_CH=3 → DROP_PACKET while pkt_valid=1 with write_enb_reg=0 and busy=0; DECODE one cycle after pkt_valid falls.
- soft_reset=3'b001 while dest=1 → no effect; soft_reset=3'b010 in FFS → DECODE next cycle. resetn low mid-LD → detect_add=1 asynchronously.
- Macro on, WAIT_LIMIT=4, destination never empties → WAIT for 4 cycles, wait_timeout pulse, DROP_PACKET; macro off → WAIT for 100+ cycles.
